// File: rtl/sha_pkg.sv
// sha_pkg: state encoding, digest sizing and the SHA-256 IV shared by the digest checker
package sha_pkg;
   localparam int WORD_CNT = 8;
   localparam int IDX_W = 3;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_LOAD   = 3'd1;
   localparam logic [2:0] S_LOADED = 3'd2;
   localparam logic [2:0] S_WAIT   = 3'd3;
   localparam logic [2:0] S_CMP    = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [0:WORD_CNT-1][31:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };
endpackage

// File: rtl/sha_timeout_cnt.sv
// sha_timeout_cnt: counts enabled cycles and flags the cycle whose edge reaches LIMIT
module sha_timeout_cnt #(
   parameter int LIMIT = 1023
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expired
);
   localparam int W = $clog2(LIMIT + 1);
   logic [W-1:0] cnt;
   always_ff @(posedge clk)
      cnt <= (!rst_n || clear) ? '0 : enable ? cnt + W'(1) : cnt;
   assign expired = enable && cnt == W'(LIMIT - 1);
endmodule

// File: rtl/sha_digest_checker.sv
// sha_digest_checker: holds an expected digest, captures the core's digest and compares it word by word
import sha_pkg::*;
module sha_digest_checker #(
   parameter int HASH_SIZE   = 256,
   parameter int MSG_BLK     = 32,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic                 usr_clk,
   input  logic                 usr_reset_n,
   input  logic                 i_clear,
   input  logic                 i_exp_wr,
   input  logic [MSG_BLK-1:0]   i_exp_word,
   input  logic                 i_arm,
   input  logic                 i_valid,
   input  logic [HASH_SIZE-1:0] i_hash,
   output logic                 o_exp_ready,
   output logic                 o_busy,
   output logic                 o_done,
   output logic                 o_match,
   output logic                 o_timeout,
   output logic [IDX_W-1:0]     o_mis_idx
);
   logic [2:0]         state;
   logic [IDX_W-1:0]   wcnt, ccnt;
   logic               mis_seen, expired, arm_ok, wr_ok, mis_now;
   logic [MSG_BLK-1:0] exp_mem [WORD_CNT];
   logic [MSG_BLK-1:0] cap_mem [WORD_CNT];

   assign wr_ok       = i_exp_wr && (state == S_IDLE || state == S_LOAD);
   assign arm_ok      = i_arm && state == S_LOADED;
   assign mis_now     = cap_mem[ccnt] != exp_mem[ccnt];
   assign o_exp_ready = state == S_IDLE || state == S_LOAD;
   assign o_busy      = state == S_WAIT || state == S_CMP;
   assign o_done      = state == S_DONE;

   sha_timeout_cnt #(.LIMIT(TIMEOUT_CYC)) u_tmo (
      .clk(usr_clk), .rst_n(usr_reset_n), .clear(arm_ok || i_clear),
      .enable(state == S_WAIT), .expired(expired)
   );

   // expected words survive DONE so a re-arm needs no reload
   always_ff @(posedge usr_clk)
      if (!usr_reset_n)
         for (int i = 0; i < WORD_CNT; i++) exp_mem[i] <= MSG_BLK'(IV[i]);
      else if (wr_ok && !i_clear)
         exp_mem[wcnt] <= i_exp_word;

   // word 0 is the most significant slice of the digest
   always_ff @(posedge usr_clk)
      if (state == S_WAIT && i_valid)
         for (int i = 0; i < WORD_CNT; i++)
            cap_mem[i] <= i_hash[HASH_SIZE-1-i*MSG_BLK -: MSG_BLK];

   always_ff @(posedge usr_clk) begin
      if (!usr_reset_n || i_clear) begin
         state     <= S_IDLE;
         wcnt      <= '0;
         ccnt      <= '0;
         mis_seen  <= 1'b0;
         o_match   <= 1'b0;
         o_timeout <= 1'b0;
         o_mis_idx <= '0;
      end else begin
         case (state)
            S_IDLE, S_LOAD:
               if (wr_ok) begin
                  wcnt  <= (wcnt == IDX_W'(WORD_CNT - 1)) ? '0 : wcnt + 1'b1;
                  state <= (wcnt == IDX_W'(WORD_CNT - 1)) ? S_LOADED : S_LOAD;
               end
            S_LOADED:
               if (arm_ok) begin
                  state     <= S_WAIT;
                  ccnt      <= '0;
                  mis_seen  <= 1'b0;
                  o_match   <= 1'b0;
                  o_timeout <= 1'b0;
                  o_mis_idx <= '0;
               end
            S_WAIT:
               if (i_valid) begin
                  state <= S_CMP;
                  ccnt  <= '0;
               end else if (expired) begin
                  state     <= S_DONE;
                  o_timeout <= 1'b1;
                  o_match   <= 1'b0;
               end
            S_CMP: begin
               ccnt <= ccnt + 1'b1;
               if (mis_now && !mis_seen) begin
                  mis_seen  <= 1'b1;
                  o_mis_idx <= ccnt;
               end
               if (ccnt == IDX_W'(WORD_CNT - 1)) begin
                  state   <= S_DONE;
                  o_match <= !(mis_seen || mis_now);
               end
            end
            S_DONE:  state <= S_LOADED;
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha_digest_checker.sv
// tb_sha_digest_checker: directed vector table plus hand sequences for timeout, clear and reset
module tb_sha_digest_checker;
   logic         usr_clk = 1'b0, usr_reset_n = 1'b0, i_clear = 1'b0;
   logic         i_exp_wr = 1'b0, i_arm = 1'b0, i_valid = 1'b0;
   logic [31:0]  i_exp_word = '0;
   logic [255:0] i_hash = '0;
   logic         o_exp_ready, o_busy, o_done, o_match, o_timeout;
   logic [2:0]   o_mis_idx;
   int           errors = 0, checks = 0;

   localparam logic [255:0] ABC = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2220,
                                   32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

   typedef struct {
      logic [255:0] hash;
      logic         match;
      logic [2:0]   idx;
   } vec_t;
   vec_t vecs[7];

   sha_digest_checker #(.HASH_SIZE(256), .MSG_BLK(32), .TIMEOUT_CYC(1023)) dut (
      .usr_clk(usr_clk), .usr_reset_n(usr_reset_n), .i_clear(i_clear), .i_exp_wr(i_exp_wr),
      .i_exp_word(i_exp_word), .i_arm(i_arm), .i_valid(i_valid), .i_hash(i_hash),
      .o_exp_ready(o_exp_ready), .o_busy(o_busy), .o_done(o_done), .o_match(o_match),
      .o_timeout(o_timeout), .o_mis_idx(o_mis_idx)
   );

   always #5 usr_clk = ~usr_clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic step;
      @(posedge usr_clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_exp_ready"}, 32'(o_exp_ready), 1);
      chk({tag, "_busy"}, 32'(o_busy), 0);
      chk({tag, "_done"}, 32'(o_done), 0);
      chk({tag, "_match"}, 32'(o_match), 0);
      chk({tag, "_timeout"}, 32'(o_timeout), 0);
      chk({tag, "_mis_idx"}, 32'(o_mis_idx), 0);
   endtask

   task automatic load(input logic [255:0] d, input int nwords);
      for (int k = 0; k < nwords; k++) begin
         i_exp_wr   = 1'b1;
         i_exp_word = d[255-32*k -: 32];
         step;
      end
      i_exp_wr = 1'b0;
   endtask

   task automatic arm;
      i_arm = 1'b1;
      step;
      i_arm = 1'b0;
   endtask

   task automatic run_to_done(input int lim, output int n);
      n = 0;
      while (!o_done && n < lim) begin
         step;
         n++;
      end
   endtask

   task automatic watch_no_done(input string nm, input int cyc);
      int seen = 0;
      for (int k = 0; k < cyc; k++) begin
         step;
         if (o_done) seen++;
      end
      chk(nm, 32'(seen), 0);
   endtask

   initial begin
      int n;
      logic [255:0] h;
      vecs[0] = '{ABC, 1'b1, 3'd0};
      h = ABC;
      h[95:64] = 32'h96177a9d;
      h[31:0]  = 32'hf20015ae;
      vecs[1] = '{h, 1'b0, 3'd5};
      vecs[2] = '{ABC ^ {32'h1, 224'h0}, 1'b0, 3'd0};
      vecs[3] = '{ABC ^ 256'h1, 1'b0, 3'd7};
      vecs[4] = '{ABC ^ {64'h0, 32'h80000000, 32'h1, 128'h0}, 1'b0, 3'd2};
      vecs[5] = '{~ABC, 1'b0, 3'd0};
      vecs[6] = '{ABC, 1'b1, 3'd0};

      step;
      step;
      chk_reset("reset");
      usr_reset_n = 1'b1;

      load(ABC, 4);
      chk("partial_exp_ready", 32'(o_exp_ready), 1);
      arm;
      chk("partial_arm_busy", 32'(o_busy), 0);
      i_clear = 1'b1;
      step;
      i_clear = 1'b0;

      load(ABC, 8);
      chk("loaded_exp_ready", 32'(o_exp_ready), 0);
      i_exp_wr   = 1'b1;
      i_exp_word = 32'hdeadbeef;
      step;
      i_exp_wr = 1'b0;

      for (int i = 0; i < 7; i++) begin
         arm;
         chk($sformatf("vec%0d_busy", i), 32'(o_busy), 1);
         chk($sformatf("vec%0d_armed_match", i), 32'(o_match), 0);
         i_hash  = vecs[i].hash;
         i_valid = 1'b1;
         step;
         i_valid = 1'b0;
         run_to_done(20, n);
         chk($sformatf("vec%0d_latency", i), 32'(n), 8);
         chk($sformatf("vec%0d_match", i), 32'(o_match), 32'(vecs[i].match));
         chk($sformatf("vec%0d_mis_idx", i), 32'(o_mis_idx), 32'(vecs[i].idx));
         chk($sformatf("vec%0d_timeout", i), 32'(o_timeout), 0);
         step;
         chk($sformatf("vec%0d_done_pulse", i), 32'(o_done), 0);
         chk($sformatf("vec%0d_match_held", i), 32'(o_match), 32'(vecs[i].match));
      end

      i_hash  = ABC;
      i_arm   = 1'b1;
      i_valid = 1'b1;
      step;
      i_arm   = 1'b0;
      i_valid = 1'b0;
      run_to_done(1100, n);
      chk("timeout_latency", 32'(n), 1023);
      chk("timeout_flag", 32'(o_timeout), 1);
      chk("timeout_match", 32'(o_timeout & o_match), 0);
      chk("timeout_mis_idx", 32'(o_mis_idx), 0);
      step;
      i_valid = 1'b1;
      step;
      i_valid = 1'b0;
      watch_no_done("late_valid_done", 12);
      chk("late_valid_busy", 32'(o_busy), 0);
      chk("late_valid_timeout_held", 32'(o_timeout), 1);

      arm;
      repeat (1022) step;
      i_valid = 1'b1;
      step;
      i_valid = 1'b0;
      chk("coincide_busy", 32'(o_busy), 1);
      chk("coincide_timeout", 32'(o_timeout), 0);
      run_to_done(20, n);
      chk("coincide_latency", 32'(n), 8);
      chk("coincide_match", 32'(o_match), 1);
      chk("coincide_timeout_done", 32'(o_timeout), 0);
      step;

      arm;
      i_valid = 1'b1;
      step;
      i_valid = 1'b0;
      repeat (3) step;
      i_clear = 1'b1;
      step;
      i_clear = 1'b0;
      chk("clear_exp_ready", 32'(o_exp_ready), 1);
      chk("clear_busy", 32'(o_busy), 0);
      chk("clear_match", 32'(o_match), 0);
      watch_no_done("clear_no_done", 12);
      arm;
      chk("idle_arm_busy", 32'(o_busy), 0);

      load(ABC, 8);
      arm;
      repeat (5) step;
      chk("midwait_busy", 32'(o_busy), 1);
      usr_reset_n = 1'b0;
      step;
      chk_reset("midwait_reset");
      usr_reset_n = 1'b1;
      step;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
